// File: rtl/sseg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with per-frame input snapshot and per-digit PWM.
// Define SSEG_LZ_BLANK_EN to compile in leading-zero blanking of the upper digits.
module sseg_scan_driver #(
  parameter int N = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] hex,
  input  logic [7:0]  dp,
  input  logic [3:0]  bright,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_tick
);

  localparam logic [N-1:0] CNT_LAST = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

`ifdef SSEG_LZ_BLANK_EN
  // A digit goes dark once every nibble and decimal point from it upward is zero.
  function automatic logic [7:0] lz_dark(input logic [31:0] h, input logic [7:0] d);
    logic [7:0] dark;
    logic       zero_run;
    dark     = 8'h00;
    zero_run = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_run = zero_run & (h[4*i +: 4] == 4'h0) & ~d[i];
      dark[i]  = zero_run;
    end
    return dark;
  endfunction
`endif

  logic [N-1:0] cnt_q, cnt_d;
  logic [31:0]  hex_s_q, hex_s_d;
  logic [7:0]   dp_s_q, dp_s_d;
  logic [3:0]   bright_s_q, bright_s_d;
  logic [7:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;
  logic         frame_tick_q, frame_tick_d;

  logic         wrap_s;
  logic [2:0]   sel_s;
  logic [3:0]   ph_s;
  logic [3:0]   nib_s;
  logic [7:0]   lz_dark_s;
  logic         dark_s;

  // Refresh counter and frame snapshot; inputs are captured only on the frame wrap.
  always_comb begin
    wrap_s = (cnt_q == CNT_LAST);
    cnt_d  = cnt_q + CNT_ONE;
    if (wrap_s) begin
      hex_s_d    = hex;
      dp_s_d     = dp;
      bright_s_d = bright;
    end else begin
      hex_s_d    = hex_s_q;
      dp_s_d     = dp_s_q;
      bright_s_d = bright_s_q;
    end
  end

  // Next anode/segment pattern from the current counter state and snapshot.
  always_comb begin
    sel_s = cnt_q[N-1:N-3];
    ph_s  = cnt_q[N-4:N-7];
    nib_s = hex_s_q[{sel_s, 2'b00} +: 4];
`ifdef SSEG_LZ_BLANK_EN
    lz_dark_s = lz_dark(hex_s_q, dp_s_q);
`else
    lz_dark_s = 8'h00;
`endif
    dark_s = blank | (ph_s > bright_s_q) | lz_dark_s[sel_s];
    if (dark_s) begin
      an_d   = 8'hFF;
      sseg_d = 8'hFF;
    end else begin
      an_d   = ~(8'h01 << sel_s);
      sseg_d = {~dp_s_q[sel_s], hex_font(nib_s)};
    end
    frame_tick_d = wrap_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= {N{1'b0}};
      hex_s_q      <= 32'h0000_0000;
      dp_s_q       <= 8'h00;
      bright_s_q   <= 4'hF;
      an_q         <= 8'hFF;
      sseg_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hex_s_q      <= hex_s_d;
      dp_s_q       <= dp_s_d;
      bright_s_q   <= bright_s_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver at N=7 (16-cycle slot, 128-cycle frame).
// Honours SSEG_LZ_BLANK_EN in its reference model.
module tb_sseg_scan_driver;

  localparam int N     = 7;
  localparam int FRAME = 128;
  localparam int SLOT  = 16;

`ifdef SSEG_LZ_BLANK_EN
  localparam logic [7:0] MASK_A5   = 8'h03;
  localparam logic [7:0] MASK_ZERO = 8'h01;
  localparam int         LIT_ZERO  = 16;
`else
  localparam logic [7:0] MASK_A5   = 8'hFF;
  localparam logic [7:0] MASK_ZERO = 8'hFF;
  localparam int         LIT_ZERO  = 128;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] hex;
  logic [7:0]  dp;
  logic [3:0]  bright;
  logic        blank;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  sseg_scan_driver #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .hex        (hex),
    .dp         (dp),
    .bright     (bright),
    .blank      (blank),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Expected {an, sseg} for a frame position, given the frame's snapshot and blank.
  function automatic logic [15:0] model_out(input int pos, input logic [31:0] h,
                                            input logic [7:0] d, input logic [3:0] b,
                                            input logic bl);
    int         dig;
    int         ph;
    int         top;
    logic       lit;
    logic [7:0] seg;
    dig = pos / SLOT;
    ph  = pos % SLOT;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      if (h[4*i +: 4] != 4'h0 || d[i]) top = i;
    end
    lit = !bl && (ph <= int'(b));
`ifdef SSEG_LZ_BLANK_EN
    if (dig > top) lit = 1'b0;
`endif
    if (!lit) return 16'hFFFF;
    seg    = font_tab[h[4*dig +: 4]];
    seg[7] = ~d[dig];
    return {~(8'h01 << dig), seg};
  endfunction

  int          m_pos;
  logic [31:0] m_hex;
  logic [7:0]  m_dp;
  logic [3:0]  m_br;
  logic [7:0]  exp_an;
  logic [7:0]  exp_sseg;
  logic        exp_tick;
  logic        model_valid = 1'b0;

  // Reference model: outputs lag the frame position by one cycle.
  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (reset) begin
      m_pos    <= 0;
      m_hex    <= 32'h0;
      m_dp     <= 8'h00;
      m_br     <= 4'hF;
      exp_an   <= 8'hFF;
      exp_sseg <= 8'hFF;
      exp_tick <= 1'b0;
    end else begin
      {exp_an, exp_sseg} <= model_out(m_pos, m_hex, m_dp, m_br, blank);
      exp_tick <= (m_pos == FRAME - 1);
      m_pos    <= (m_pos + 1) % FRAME;
      if (m_pos == FRAME - 1) begin
        m_hex <= hex;
        m_dp  <= dp;
        m_br  <= bright;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      total++;
      if (an !== exp_an) begin
        bad++;
        $display("FAIL model_an t=%0t: got %h, want %h", $time, an, exp_an);
      end
      total++;
      if (sseg !== exp_sseg) begin
        bad++;
        $display("FAIL model_sseg t=%0t: got %h, want %h", $time, sseg, exp_sseg);
      end
      total++;
      if (frame_tick !== exp_tick) begin
        bad++;
        $display("FAIL model_tick t=%0t: got %b, want %b", $time, frame_tick, exp_tick);
      end
    end
  end

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  // Waits for frame_tick; exp_n < 0 means only the timeout is checked.
  task automatic wait_tick(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 300);
    total++;
    if (!frame_tick || (exp_n >= 0 && n != exp_n)) begin
      bad++;
      $display("FAIL %s: tick after %0d cycles, want %0d", name, n, exp_n);
    end
    #1;
  endtask

  task automatic count_frame(input string name, output int lit, output logic [7:0] m);
    lit = 0;
    m   = 8'h00;
    repeat (FRAME) begin
      @(negedge clk);
      if (an !== 8'hFF) lit++;
      m = m | ~an;
    end
    total++;
    if (frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL %s_period: frame_tick got %b, want 1", name, frame_tick);
    end
    #1;
  endtask

  int         lit;
  logic [7:0] msk;
  int         r;

  initial begin
    reset  = 1'b1;
    hex    = 32'h0;
    dp     = 8'h00;
    bright = 4'hF;
    blank  = 1'b0;

    chk8("pin_dig0_an",   model_out(0, 32'h7654_3210, 8'h00, 4'hF, 1'b0)[15:8], 8'hFE);
    chk8("pin_dig0_sseg", model_out(0, 32'h7654_3210, 8'h00, 4'hF, 1'b0)[7:0],  8'hC0);
    chk8("pin_dig2_an",   model_out(2*SLOT+5, 32'h7654_3210, 8'h00, 4'hF, 1'b0)[15:8], 8'hFB);
    chk8("pin_dig2_sseg", model_out(2*SLOT+5, 32'h7654_3210, 8'h00, 4'hF, 1'b0)[7:0],  8'hA4);
    chk8("pin_pwm_off",   model_out(3*SLOT+4, 32'h7654_3210, 8'h00, 4'h3, 1'b0)[15:8], 8'hFF);
    chk8("pin_dp",        model_out(0, 32'h0, 8'h01, 4'hF, 1'b0)[7:0], 8'h40);
    chk8("pin_blank",     model_out(7*SLOT, 32'hFFFF_FFFF, 8'h00, 4'hF, 1'b1)[7:0], 8'hFF);

    repeat (5) @(negedge clk);
    chk8("reset_an", an, 8'hFF);
    chk8("reset_sseg", sseg, 8'hFF);
    #1;
    hex   = 32'h7654_3210;
    reset = 1'b0;

    wait_tick("first_tick", FRAME);
    @(negedge clk);
    chk8("scan_d0_an", an, 8'hFE);
    chk8("scan_d0_sseg", sseg, 8'hC0);
    repeat (SLOT) @(negedge clk);
    chk8("scan_d1_an", an, 8'hFD);
    chk8("scan_d1_sseg", sseg, 8'hF9);
    #1;
    hex = 32'hFFFF_FFFF;
    wait_tick("tear_tick", FRAME - SLOT - 1);
    @(negedge clk);
    chk8("tear_new_an", an, 8'hFE);
    chk8("tear_new_sseg", sseg, 8'h8E);
    #1;
    bright = 4'h3;

    wait_tick("pwm_tick", FRAME - 1);
    bright = 4'h0;
    count_frame("pwm3", lit, msk);
    chk_int("pwm3_lit", lit, 32);
    count_frame("pwm0", lit, msk);
    chk_int("pwm0_lit", lit, 8);

    hex    = 32'h0;
    dp     = 8'h01;
    bright = 4'hF;
    wait_tick("dp_tick", FRAME);
    @(negedge clk);
    chk8("dp_an", an, 8'hFE);
    chk8("dp_sseg", sseg, 8'h40);
    #1;
    hex = 32'h0000_00A5;
    dp  = 8'h00;
    wait_tick("a5_tick", FRAME - 1);
    count_frame("a5", lit, msk);
    chk8("a5_mask", msk, MASK_A5);
    hex = 32'h0;
    wait_tick("zero_tick", FRAME);
    count_frame("zero", lit, msk);
    chk8("zero_mask", msk, MASK_ZERO);
    chk_int("zero_lit", lit, LIT_ZERO);

    hex = 32'hFFFF_FFFF;
    wait_tick("blank_tick", FRAME);
    repeat (5) @(negedge clk);
    #1;
    blank = 1'b1;
    @(negedge clk);
    chk8("blank_an", an, 8'hFF);
    chk8("blank_sseg", sseg, 8'hFF);
    #1;
    blank = 1'b0;
    @(negedge clk);
    chk8("unblank_an", an, 8'hFE);
    chk8("unblank_sseg", sseg, 8'h8E);

    repeat (20) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk8("midreset_an", an, 8'hFF);
    chk8("midreset_sseg", sseg, 8'hFF);
    #1;
    reset = 1'b0;
    wait_tick("midreset_tick", FRAME);

    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      #1;
      r = int'($urandom_range(0, 99));
      if (r < 4) hex = $urandom >> (4 * $urandom_range(0, 8));
      if (r >= 4 && r < 7) dp = 8'($urandom_range(0, 255)) & (8'hFF >> $urandom_range(0, 8));
      if (r >= 7 && r < 9) bright = 4'($urandom_range(0, 15));
      if (r >= 9 && r < 12) blank = ~blank;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    blank = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
